// File: rtl/paddle_axis_emu.sv
// Paddle/analog-axis emulator: merges PS/2 mouse motion and analog joystick axes
// into two signed paddle positions and three fire buttons.
module paddle_axis_emu #(
   parameter int W        = 8,
   parameter int STEP_MAX = 10,
   parameter int DZ       = 4
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [24:0]         ps2_mouse,
   input  logic [15:0]         joya,
   input  logic [2:0]          joy_btn,
   input  logic [1:0]          sens,
   input  logic                wrap,
   input  logic [1:0]          inv,
   input  logic                recenter,
   output logic signed [W-1:0] ax,
   output logic signed [W-1:0] ay,
   output logic [2:0]          btn,
   output logic                src_mouse,
   output logic                upd
);
   localparam logic signed [W:0] SAT_HI  = {2'b00, {(W-1){1'b1}}};
   localparam logic signed [W:0] SAT_LO  = {2'b11, {(W-1){1'b0}}};
   localparam logic signed [W:0] STEP_HI = (W+1)'(STEP_MAX);
   localparam logic signed [W:0] STEP_LO = -STEP_HI;
   localparam logic [8:0]        DZ_MAG  = 9'(DZ);

   logic                stb_reg;
   logic                src_reg;
   logic                src_next;
   logic                upd_reg;
   logic [2:0]          latch_reg;
   logic [2:0]          latch_next;
   logic [2:0]          btn_reg;
   logic [2:0]          btn_next;
   logic                packet;
   logic                takeover;
   logic                accept;
   logic [1:0]          over_dz;
   logic signed [W-1:0] axis_out [2];
   logic                unused_bits;

   assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3]};

   // Takeover outranks recenter, which outranks a packet.
   assign packet     = ps2_mouse[24] != stb_reg;
   assign takeover   = |over_dz;
   assign accept     = packet && !takeover && !recenter;
   assign src_next   = takeover ? 1'b0 : (accept ? 1'b1 : src_reg);
   assign latch_next = accept ? ps2_mouse[2:0] : latch_reg;
   assign btn_next   = src_next ? latch_next : joy_btn;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         logic [7:0]          joy_byte;
         logic [8:0]          joy_mag;
         logic signed [8:0]   delta;
         logic signed [8:0]   shifted;
         logic signed [W:0]   shifted_ext;
         logic signed [W:0]   step;
         logic signed [W:0]   sum;
         logic signed [W-1:0] joy_pos;
         logic signed [W-1:0] acc_step;
         logic signed [W-1:0] acc_next;
         logic signed [W-1:0] out_next;
         logic signed [W-1:0] acc_reg;
         logic signed [W-1:0] out_reg;

         // -128 must count as magnitude 128, hence the 9-bit magnitude.
         assign joy_byte    = joya[8*gi +: 8];
         assign joy_mag     = joy_byte[7] ? (9'd256 - {1'b0, joy_byte}) : {1'b0, joy_byte};
         assign over_dz[gi] = joy_mag > DZ_MAG;
         assign joy_pos     = W'($signed(joy_byte)) <<< (W-8);

         assign delta       = $signed({ps2_mouse[4+gi], ps2_mouse[8+8*gi +: 8]});
         assign shifted     = delta >>> sens;
         assign shifted_ext = (W+1)'(shifted);

         always_comb begin
            if (shifted_ext > STEP_HI)
               step = STEP_HI;
            else if (shifted_ext < STEP_LO)
               step = STEP_LO;
            else
               step = shifted_ext;
         end

         assign sum = (W+1)'(acc_reg) + step;

         always_comb begin
            if (wrap)
               acc_step = sum[W-1:0];
            else if (sum > SAT_HI)
               acc_step = SAT_HI[W-1:0];
            else if (sum < SAT_LO)
               acc_step = SAT_LO[W-1:0];
            else
               acc_step = sum[W-1:0];
         end

         always_comb begin
            if (takeover || recenter)
               acc_next = '0;
            else if (accept)
               acc_next = acc_step;
            else
               acc_next = acc_reg;
         end

         assign out_next = (src_next ? acc_next : joy_pos) ^ {W{inv[gi]}};

         always_ff @(posedge clk_sys) begin
            if (reset) begin
               acc_reg <= '0;
               out_reg <= '0;
            end else begin
               acc_reg <= acc_next;
               out_reg <= out_next;
            end
         end

         assign axis_out[gi] = out_reg;
      end
   endgenerate

   // The strobe tracks the toggle even in reset so release never looks like a packet.
   always_ff @(posedge clk_sys) begin
      stb_reg <= ps2_mouse[24];
      if (reset) begin
         src_reg   <= 1'b0;
         upd_reg   <= 1'b0;
         latch_reg <= 3'b000;
         btn_reg   <= 3'b000;
      end else begin
         src_reg   <= src_next;
         upd_reg   <= accept;
         latch_reg <= latch_next;
         btn_reg   <= btn_next;
      end
   end

   assign ax        = axis_out[0];
   assign ay        = axis_out[1];
   assign btn       = btn_reg;
   assign src_mouse = src_reg;
   assign upd       = upd_reg;
endmodule

// File: tb/tb_paddle_axis_emu.sv
// Self-checking bench for paddle_axis_emu: integer-level behavioural model compared
// every cycle, plus directed literal expectations.
module tb_paddle_axis_emu;
   localparam int W        = 8;
   localparam int STEP_MAX = 10;
   localparam int DZ       = 4;

   logic                clk_sys = 1'b0;
   logic                reset;
   logic [24:0]         ps2_mouse;
   logic [15:0]         joya;
   logic [2:0]          joy_btn;
   logic [1:0]          sens;
   logic                wrap;
   logic [1:0]          inv;
   logic                recenter;
   logic signed [W-1:0] ax;
   logic signed [W-1:0] ay;
   logic [2:0]          btn;
   logic                src_mouse;
   logic                upd;

   int checks   = 0;
   int failures = 0;

   always #5 clk_sys = ~clk_sys;

   paddle_axis_emu #(.W(W), .STEP_MAX(STEP_MAX), .DZ(DZ)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ps2_mouse (ps2_mouse),
      .joya      (joya),
      .joy_btn   (joy_btn),
      .sens      (sens),
      .wrap      (wrap),
      .inv       (inv),
      .recenter  (recenter),
      .ax        (ax),
      .ay        (ay),
      .btn       (btn),
      .src_mouse (src_mouse),
      .upd       (upd)
   );

   // ---------------- behavioural model (plain integers) ----------------
   int       m_acc [2];
   bit       m_stb;
   bit       m_src;
   bit [2:0] m_latch;
   bit       m_valid = 1'b0;
   int       e_ax, e_ay;
   bit [2:0] e_btn;
   bit       e_src, e_upd;

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int wrapw(int v);
      int m, h, r;
      m = 1 << W;
      h = m / 2;
      r = (v + h) % m;
      if (r < 0) r += m;
      return r - h;
   endfunction

   function automatic int next_acc(int acc, int d, int sh, bit wr);
      int s, c, sum, lo, hi;
      s  = d >>> sh;
      c  = (s > STEP_MAX) ? STEP_MAX : ((s < -STEP_MAX) ? -STEP_MAX : s);
      sum = acc + c;
      if (wr) return wrapw(sum);
      lo = -(1 << (W-1));
      hi = (1 << (W-1)) - 1;
      return (sum > hi) ? hi : ((sum < lo) ? lo : sum);
   endfunction

   always @(posedge clk_sys) begin : model_blk
      int jx, jy, dx, dy, xv, yv;
      bit pkt, take;
      if (reset) begin
         m_stb   = ps2_mouse[24];
         m_acc[0] = 0;
         m_acc[1] = 0;
         m_src   = 1'b0;
         m_latch = 3'b000;
         e_ax = 0; e_ay = 0; e_btn = 3'b000; e_src = 1'b0; e_upd = 1'b0;
      end else begin
         pkt   = ps2_mouse[24] != m_stb;
         m_stb = ps2_mouse[24];
         jx    = int'($signed(joya[7:0]));
         jy    = int'($signed(joya[15:8]));
         take  = (iabs(jx) > DZ) || (iabs(jy) > DZ);
         e_upd = 1'b0;
         if (take) begin
            m_src = 1'b0;
            m_acc[0] = 0;
            m_acc[1] = 0;
         end else if (recenter) begin
            m_acc[0] = 0;
            m_acc[1] = 0;
         end else if (pkt) begin
            dx = ps2_mouse[4] ? int'(ps2_mouse[15:8]) - 256 : int'(ps2_mouse[15:8]);
            dy = ps2_mouse[5] ? int'(ps2_mouse[23:16]) - 256 : int'(ps2_mouse[23:16]);
            m_acc[0] = next_acc(m_acc[0], dx, int'(sens), wrap);
            m_acc[1] = next_acc(m_acc[1], dy, int'(sens), wrap);
            m_src   = 1'b1;
            m_latch = ps2_mouse[2:0];
            e_upd   = 1'b1;
         end
         xv    = m_src ? m_acc[0] : jx * (1 << (W-8));
         yv    = m_src ? m_acc[1] : jy * (1 << (W-8));
         e_ax  = inv[0] ? -xv - 1 : xv;
         e_ay  = inv[1] ? -yv - 1 : yv;
         e_btn = m_src ? m_latch : joy_btn;
         e_src = m_src;
      end
      m_valid = 1'b1;
   end

   always @(negedge clk_sys) begin
      if (m_valid) begin
         checks++;
         if (int'(ax) != e_ax || int'(ay) != e_ay || btn != e_btn ||
             src_mouse != e_src || upd != e_upd) begin
            failures++;
            $display("FAIL model t=%0t: got ax=%0d ay=%0d btn=%0d src=%0d upd=%0d, required ax=%0d ay=%0d btn=%0d src=%0d upd=%0d",
                     $time, ax, ay, btn, src_mouse, upd, e_ax, e_ay, e_btn, e_src, e_upd);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic pkt(int dx, int dy, logic [2:0] b);
      ps2_mouse[24]    = ~ps2_mouse[24];
      ps2_mouse[4]     = dx < 0;
      ps2_mouse[15:8]  = dx[7:0];
      ps2_mouse[5]     = dy < 0;
      ps2_mouse[23:16] = dy[7:0];
      ps2_mouse[2:0]   = b;
      tick(1);
      $display("pkt dx=%0d dy=%0d sens=%0d wrap=%0d rc=%0d joya=%h -> ax=%0d ay=%0d btn=%0d src=%0d upd=%0d",
               dx, dy, sens, wrap, recenter, joya, ax, ay, btn, src_mouse, upd);
   endtask

   initial begin
      reset     = 1'b1;
      ps2_mouse = 25'h1000000;
      joya      = 16'h0000;
      joy_btn   = 3'b000;
      sens      = 2'd0;
      wrap      = 1'b0;
      inv       = 2'b00;
      recenter  = 1'b0;
      tick(3);
      chk("reset_ax", int'(ax), 0);
      chk("reset_src", int'(src_mouse), 0);
      chk("reset_upd", int'(upd), 0);
      reset = 1'b0;
      tick(1);
      chk("release_no_upd", int'(upd), 0);
      chk("release_src", int'(src_mouse), 0);

      // basic packet
      pkt(5, 0, 3'b101);
      chk("basic_ax", int'(ax), 5);
      chk("basic_ay", int'(ay), 0);
      chk("basic_upd", int'(upd), 1);
      chk("basic_src", int'(src_mouse), 1);
      chk("basic_btn", int'(btn), 5);
      tick(1);
      chk("upd_one_cycle", int'(upd), 0);
      chk("hold_ax", int'(ax), 5);

      // saturate, then wrap
      recenter = 1'b1;
      tick(1);
      recenter = 1'b0;
      chk("recenter_ax", int'(ax), 0);
      for (int i = 1; i <= 14; i++) begin
         pkt(10, 0, 3'b000);
         chk("b2b_upd", int'(upd), 1);
         if (i == 12) chk("sat_12", int'(ax), 120);
         if (i == 13) chk("sat_13", int'(ax), 127);
      end
      chk("sat_14", int'(ax), 127);
      chk("sat_ay_indep", int'(ay), 0);
      recenter = 1'b1;
      tick(1);
      recenter = 1'b0;
      for (int i = 0; i < 12; i++) pkt(10, 0, 3'b000);
      wrap = 1'b1;
      pkt(10, 0, 3'b000);
      chk("wrap_ax", int'(ax), -126);
      wrap = 1'b0;

      // shift and clamp
      recenter = 1'b1;
      tick(1);
      recenter = 1'b0;
      pkt(-200, 0, 3'b000);
      chk("clamp_sens0", int'(ax), -10);
      sens = 2'd3;
      pkt(-200, 0, 3'b000);
      chk("clamp_sens3", int'(ax), -20);
      sens = 2'd2;
      pkt(20, 0, 3'b000);
      chk("shift_sens2", int'(ax), -15);
      sens = 2'd1;
      pkt(0, -7, 3'b000);
      chk("shift_neg_floor", int'(ay), -4);
      sens = 2'd0;

      // deadzone and takeover
      joya = 16'h0003;
      tick(1);
      chk("dz_src", int'(src_mouse), 1);
      chk("dz_ax", int'(ax), -15);
      joya    = 16'h0020;
      joy_btn = 3'b110;
      tick(1);
      chk("take_src", int'(src_mouse), 0);
      chk("take_ax", int'(ax), 32);
      chk("take_btn", int'(btn), 6);
      joya = 16'h0080;
      tick(1);
      chk("analog_min", int'(ax), -128);
      joya = 16'hFB00;
      tick(1);
      chk("analog_ay", int'(ay), -5);
      joya = 16'hFC00;
      tick(1);
      chk("analog_persist_ay", int'(ay), -4);
      joya = 16'h0000;
      tick(1);
      chk("analog_persist_src", int'(src_mouse), 0);
      pkt(1, 0, 3'b010);
      chk("back_ax", int'(ax), 1);
      chk("back_src", int'(src_mouse), 1);
      chk("back_btn", int'(btn), 2);

      // simultaneous events
      pkt(3, 0, 3'b010);
      recenter = 1'b1;
      pkt(2, 2, 3'b111);
      chk("rc_pkt_ax", int'(ax), 0);
      chk("rc_pkt_upd", int'(upd), 0);
      chk("rc_pkt_btn", int'(btn), 2);
      recenter = 1'b0;
      joya = 16'h0020;
      pkt(2, 0, 3'b000);
      chk("take_pkt_src", int'(src_mouse), 0);
      chk("take_pkt_upd", int'(upd), 0);
      joya = 16'h0000;
      tick(1);
      pkt(5, 0, 3'b000);
      chk("mouse_again_ax", int'(ax), 5);

      // inversion
      inv = 2'b01;
      tick(1);
      chk("inv_ax", int'(ax), -6);
      inv = 2'b00;
      tick(1);
      chk("uninv_ax", int'(ax), 5);
      inv = 2'b10;
      tick(1);
      chk("inv_ay", int'(ay), -1);
      inv   = 2'b11;
      reset = 1'b1;
      tick(2);
      chk("inv_reset_ax", int'(ax), 0);
      reset = 1'b0;
      tick(1);
      chk("inv_post_reset_ax", int'(ax), -1);
      chk("inv_post_reset_ay", int'(ay), -1);
      inv = 2'b00;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
